mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DEPTH, default 100, number of 32-bit words in the attached data memory.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 req_valid  input  1  processor access request.
REQ-005 req_op  input  3  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB.
REQ-006 req_addr  input  32  byte address.
REQ-007 req_wdata  input  32  store data; SH uses bits [15:0], SB uses bits [7:0].
REQ-008 req_ready  output  1  unit idle and able to accept a request.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 err  output  1  completion was an error; valid only with done.
REQ-011 rdata  output  32  load result, extended per op; held until the next load completes.
REQ-012 mem_we  output  1  write enable to the data memory.
REQ-013 mem_a  output  32  word index to the data memory, {2'b00, addr[31:2]}.
REQ-014 mem_wd  output  32  write data to the data memory.
REQ-015 mem_rd  input  32  combinational read data of word mem_a, valid in the same cycle.

Function
REQ-016 FSM states are IDLE, LOAD, RMW_RD, WRITE, FIN, and ERR; req_ready = 1 only in IDLE.
REQ-017 Accept a request at a posedge with state = IDLE and req_valid = 1; latch op, addr, and wdata; ignore req_valid in any other state.
REQ-018 Error on acceptance: LW/SW with addr[1:0] != 0, LH/LHU/SH with addr[0] = 1, or addr[31:2] >= DEPTH -> ERR.
REQ-019 Non-error transitions from IDLE on acceptance: loads -> LOAD, SW -> WRITE, SH/SB -> RMW_RD.
REQ-020 LOAD: mem_a = latched word index; at the edge, capture the extracted mem_rd into rdata; -> FIN.
REQ-021 Little-endian lane select: byte lane = addr[1:0], halfword lane = addr[1].
REQ-022 Extension: LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
REQ-023 RMW_RD: mem_a = word index; register mem_rd with the selected byte or halfword lane replaced by wdata[7:0] or wdata[15:0]; other lanes unchanged; -> WRITE.
REQ-024 WRITE: mem_we = 1 for exactly this one cycle; mem_a = word index; mem_wd = wdata (SW) or merged word (SH/SB); -> FIN.
REQ-025 FIN: done = 1, err = 0; -> IDLE.
REQ-026 ERR: done = 1, err = 1; no memory access; rdata unchanged; -> IDLE.
REQ-027 Latency from the accepting edge to the done cycle: load 2 cycles, SW 2 cycles, SH/SB 3 cycles, error 1 cycle.
REQ-028 Outside WRITE, mem_we = 0 and mem_wd = 0; in IDLE/FIN/ERR, mem_a holds its last value.
REQ-029 A request held at req_valid = 1 through FIN is accepted on the first IDLE edge; back-to-back throughput is one access per latency + 1 cycles.
REQ-030 Stores never modify rdata.

Reset
REQ-031 With reset = 1 at a posedge: state = IDLE; rdata, mem_a, mem_wd, latched op, latched addr, and latched wdata = 0; done = err = mem_we = 0.
REQ-032 Reset has priority over all other inputs, including in any state mid-access.
REQ-033 Reset in WRITE aborts the cycle: mem_we = 0 after that edge, and no further write occurs.
REQ-034 req_ready = 1 from the first cycle after reset is released.

Verification
REQ-035 Word 3 = 0x8899AABB; LB addr 0x0D -> done 2 cycles after accept, rdata = 0xFFFFFFAA; LBU addr 0x0D -> rdata = 0x000000AA.
REQ-036 Word 3 = 0x8899AABB; SH addr 0x0E, wdata 0x00001234 -> exactly one mem_we cycle at mem_a = 3 with mem_wd = 0x1234AABB; done 3 cycles after accept.
REQ-037 SW addr 0x06 -> err = 1 with done 1 cycle after accept, mem_we never asserted; LW addr 400 with DEPTH = 100 -> same response.
REQ-038 SB addr 0x00, wdata 0x5A, then immediate LW addr 0x00 with word 0 = 0 -> rdata = 0x0000005A.
REQ-039 Reset asserted during RMW_RD of an SB -> next cycle IDLE, req_ready = 1, mem_we stays 0, memory contents unchanged.
REQ-040 req_valid held high during a busy load; second request accepted only in IDLE; done pulses count equals accepted requests.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store sequencer sitting between a processor port and a single-ported
// word memory with combinational read. Sub-word stores use read-modify-write.
//
//   state  | meaning
//   IDLE   | ready for a request
//   LOAD   | read the word, capture the extended lane into rdata
//   RMW_RD | read the word, merge the store lane into it
//   WRITE  | one-cycle write strobe to memory
//   FIN    | successful completion pulse
//   ERR    | error completion pulse, no memory access
module mem_access_unit #(
  parameter int DEPTH = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic [2:0] {
    IDLE, LOAD, RMW_RD, WRITE, FIN, ERR
  } state_t;

  state_t      state, state_n;
  logic [2:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic [31:0] mem_a_hold;
  logic [31:0] load_val;
  logic [31:0] merge_val;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        acc_err;
  logic        busy_mem;

  // Request legality: alignment for the access size, and word index in range.
  always_comb begin
    acc_err = 1'b0;
    case (req_op)
      OP_LW, OP_SW:         acc_err = (req_addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: acc_err = req_addr[0];
      default:              acc_err = 1'b0;
    endcase
    if ({2'b00, req_addr[31:2]} >= DEPTH_W) acc_err = 1'b1;
  end

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    byte_sel  = mem_rd[{addr_q[1:0], 3'b000} +: 8];
    half_sel  = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
    load_val  = mem_rd;
    merge_val = mem_rd;
    case (op_q)
      OP_LH:   load_val = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_val = {16'h0000, half_sel};
      OP_LB:   load_val = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_val = {24'h000000, byte_sel};
      default: load_val = mem_rd;
    endcase
    if (op_q == OP_SH) begin
      if (addr_q[1]) merge_val[31:16] = wdata_q[15:0];
      else           merge_val[15:0]  = wdata_q[15:0];
    end else begin
      merge_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  // Next-state and control outputs.
  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    mem_we    = 1'b0;
    mem_wd    = 32'h0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (acc_err) begin
            state_n = ERR;
          end else begin
            case (req_op)
              OP_SW:        state_n = WRITE;
              OP_SH, OP_SB: state_n = RMW_RD;
              default:      state_n = LOAD;
            endcase
          end
        end
      end
      LOAD:   state_n = FIN;
      RMW_RD: state_n = WRITE;
      WRITE: begin
        mem_we  = 1'b1;
        mem_wd  = (op_q == OP_SW) ? wdata_q : merge_q;
        state_n = FIN;
      end
      FIN: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      ERR: begin
        done    = 1'b1;
        err     = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Memory address: live word index while accessing, last index otherwise.
  always_comb begin
    busy_mem = (state == LOAD) || (state == RMW_RD) || (state == WRITE);
    mem_a    = busy_mem ? {2'b00, addr_q[31:2]} : mem_a_hold;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Request latches, load result, merged store word and held address.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= 3'd0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      merge_q    <= 32'h0;
      rdata      <= 32'h0;
      mem_a_hold <= 32'h0;
    end else begin
      if (state == IDLE && req_valid) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (busy_mem) mem_a_hold <= {2'b00, addr_q[31:2]};
      if (state == LOAD) rdata <= load_val;
      if (state == RMW_RD) merge_q <= merge_val;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit with an attached word memory.
module tb_mem_access_unit;
  localparam int DEPTH = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready, done, err, mem_we;
  logic [31:0] rdata, mem_a, mem_wd, mem_rd;

  mem_access_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .done(done), .err(err), .rdata(rdata), .mem_we(mem_we), .mem_a(mem_a),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic        copy_all = 1'b0;
  int          cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (copy_all) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= ref_mem[i];
    end else if (mem_we && mem_a < DEPTH) begin
      mem[mem_a] <= mem_wd;
    end
  end

  always_comb begin
    mem_rd = 32'hDEADBEEF;
    if (mem_a < DEPTH) mem_rd = mem[mem_a];
  end

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          acc;
    logic        has_wr;
    logic [31:0] wa;
    logic [31:0] wd;
  } exp_t;

  exp_t        q[$];
  logic [31:0] rdata_m = 32'h0;
  int          checks = 0;
  int          failures = 0;
  int          issued = 0;
  int          dones = 0;
  int          wr_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // Reference behaviour straight from the access rules, on a word array.
  task automatic model(input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, output exp_t e);
    int unsigned lane, idx, sh;
    logic [31:0] w, v, mask;
    lane = addr % 4;
    idx  = addr / 4;
    e.err = 1'b0; e.has_wr = 1'b0; e.wa = 0; e.wd = 0; e.acc = 0;
    if ((op == 0 || op == 5) && lane != 0) e.err = 1'b1;
    if ((op == 1 || op == 2 || op == 6) && (addr % 2) != 0) e.err = 1'b1;
    if (idx >= DEPTH) e.err = 1'b1;
    if (e.err) begin
      e.lat = 1;
    end else if (op <= 4) begin
      w = ref_mem[idx];
      if (op == 0) begin
        v = w;
      end else if (op == 1 || op == 2) begin
        v = (w >> (16 * (lane / 2))) & 32'hFFFF;
        if (op == 1 && v >= 32'h8000) v = v + 32'hFFFF0000;
      end else begin
        v = (w >> (8 * lane)) & 32'hFF;
        if (op == 3 && v >= 32'h80) v = v + 32'hFFFFFF00;
      end
      rdata_m = v;
      e.lat = 2;
    end else begin
      w = ref_mem[idx];
      if (op == 5) begin
        v = wdata; e.lat = 2;
      end else begin
        sh   = (op == 6) ? 16 * (lane / 2) : 8 * lane;
        mask = ((op == 6) ? 32'hFFFF : 32'hFF) << sh;
        v    = (w & ~mask) | ((wdata << sh) & mask);
        e.lat = 3;
      end
      ref_mem[idx] = v;
      e.has_wr = 1'b1; e.wa = idx; e.wd = v;
    end
    e.rdata = rdata_m;
  endtask

  // Called at a negedge; holds req_valid high until the unit takes it.
  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int   k;
    req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      flag("ready_timeout");
      return;
    end
    model(op, addr, wdata, e);
    e.acc = cyc + 1;
    q.push_back(e);
    issued++;
    @(negedge clk);
  endtask

  task automatic drain();
    int k;
    req_valid = 1'b0;
    k = 0;
    while (q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) flag("drain_timeout");
    @(negedge clk);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (mem_we) begin
          if (q.size() == 0 || !q[0].has_wr || wr_seen != 0) begin
            flag("unexpected_write");
          end else begin
            chk("write_addr", mem_a, q[0].wa);
            chk("write_data", mem_wd, q[0].wd);
          end
          wr_seen++;
        end
        if (done) begin
          if (q.size() == 0) begin
            flag("spurious_done");
          end else begin
            e = q.pop_front();
            chk("err", {31'b0, err}, {31'b0, e.err});
            chk("rdata", rdata, e.rdata);
            chk("latency", cyc - e.acc + 1, e.lat);
            chk("write_count", wr_seen, e.has_wr ? 1 : 0);
            dones++;
          end
          wr_seen = 0;
        end
      end
    end
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] addr, wd;
    int          r;
    fork
      monitor();
    join_none

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;
    ref_mem[0] = 32'h0;
    ref_mem[3] = 32'h8899AABB;
    reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_addr = 0; req_wdata = 0;
    copy_all = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_err", {31'b0, err}, 32'd0);
    chk("reset_we", {31'b0, mem_we}, 32'd0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_mem_a", mem_a, 32'h0);
    chk("reset_mem_wd", mem_wd, 32'h0);
    reset = 1'b0;
    copy_all = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {31'b0, req_ready}, 32'd1);

    // Directed cases, back to back with req_valid held high.
    issue(3'd3, 32'h0D, $urandom);
    issue(3'd4, 32'h0D, $urandom);
    issue(3'd6, 32'h0E, 32'h00001234);
    issue(3'd5, 32'h06, $urandom);
    issue(3'd0, 32'd400, $urandom);
    issue(3'd7, 32'h00, 32'h0000005A);
    issue(3'd0, 32'h00, $urandom);
    drain();
    chk("sh_word3", mem[3], 32'h1234AABB);
    chk("sb_lw_rdata", rdata, 32'h0000005A);

    // Reset while an SB is in its read phase.
    req_op = 3'd7; req_addr = 32'h14; req_wdata = $urandom; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("busy_ready", {31'b0, req_ready}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_we", {31'b0, mem_we}, 32'd0);
    chk("abort_rdata", rdata, 32'h0);
    rdata_m = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_write", {31'b0, mem_we}, 32'd0);
    end
    chk("abort_mem5", mem[5], ref_mem[5]);

    // Randomized traffic with occasional idle gaps.
    for (int n = 0; n < 400; n++) begin
      op = 3'($urandom_range(0, 7));
      r  = $urandom_range(0, 9);
      if (r == 0)      addr = $urandom;
      else if (r == 1) addr = DEPTH * 4 + $urandom_range(0, 15);
      else             addr = $urandom_range(0, DEPTH * 4 - 1);
      wd = $urandom;
      issue(op, addr, wd);
      if ($urandom_range(0, 3) == 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
      end
    end
    drain();
    chk("done_count", dones, issued);
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i] !== ref_mem[i]) chk("final_mem", mem[i], ref_mem[i]);
    end
    chk("final_mem_w0", mem[0], ref_mem[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
